// File: rtl/cy6264_ctrl_if.sv
// Signal bundle between the two requesting clients, cy6264_ctrl and the CY6264 pins.
interface cy6264_ctrl_if;
  logic        a_req;
  logic        a_wr;
  logic [12:0] a_addr;
  logic [7:0]  a_wdata;
  logic        a_ack;
  logic [7:0]  a_rdata;
  logic        b_req;
  logic        b_wr;
  logic [12:0] b_addr;
  logic [7:0]  b_wdata;
  logic        b_ack;
  logic [7:0]  b_rdata;
  logic [12:0] sram_addr;
  logic        sram_lce1;
  logic        sram_ce2;
  logic        sram_lwe;
  logic        sram_loe;
  logic [7:0]  sram_dout;
  logic        sram_doe;
  logic [7:0]  sram_din;

  modport slave (
    input  a_req, a_wr, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_wr, b_addr, b_wdata,
    output b_ack, b_rdata,
    output sram_addr, sram_lce1, sram_ce2, sram_lwe, sram_loe, sram_dout, sram_doe,
    input  sram_din
  );

  modport master (
    output a_req, a_wr, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_wr, b_addr, b_wdata,
    input  b_ack, b_rdata,
    input  sram_addr, sram_lce1, sram_ce2, sram_lwe, sram_loe, sram_dout, sram_doe,
    output sram_din
  );
endinterface

// File: rtl/cy6264_ctrl.sv
// Two-port round-robin controller for the CY6264 8K x 8 async SRAM with
// programmable read/write strobe widths.
module cy6264_ctrl #(
  parameter int unsigned WAIT_RD = 2,
  parameter int unsigned WAIT_WR = 2
) (
  input  logic         clk,
  input  logic         lrst,
  cy6264_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt_b_q, gnt_b_d;
  logic        last_b_q, last_b_d;
  logic        wr_q, wr_d;
  logic [12:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  a_rdata_q, a_rdata_d;
  logic [7:0]  b_rdata_q, b_rdata_d;

  logic pick_b;
  logic lce1, ce2, lwe, loe, doe, a_ack, b_ack;

  // B wins when it is the only requester, or on a tie when A was granted last.
  assign pick_b = bus.b_req && (!bus.a_req || !last_b_q);

  always_ff @(posedge clk) begin
    if (!lrst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      gnt_b_q   <= 1'b0;
      last_b_q  <= 1'b1;
      wr_q      <= 1'b0;
      addr_q    <= 13'd0;
      wdata_q   <= 8'd0;
      a_rdata_q <= 8'd0;
      b_rdata_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_b_q   <= gnt_b_d;
      last_b_q  <= last_b_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_b_d   = gnt_b_q;
    last_b_d  = last_b_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    lce1      = 1'b1;
    ce2       = 1'b0;
    lwe       = 1'b1;
    loe       = 1'b1;
    doe       = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          gnt_b_d  = pick_b;
          last_b_d = pick_b;
          wr_d     = pick_b ? bus.b_wr    : bus.a_wr;
          addr_d   = pick_b ? bus.b_addr  : bus.a_addr;
          wdata_d  = pick_b ? bus.b_wdata : bus.a_wdata;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        lce1    = 1'b0;
        ce2     = 1'b1;
        doe     = wr_q;
        cnt_d   = wr_q ? 8'(WAIT_WR) : 8'(WAIT_RD);
        state_d = ACCESS;
      end
      ACCESS: begin
        lce1 = 1'b0;
        ce2  = 1'b1;
        doe  = wr_q;
        lwe  = !wr_q;
        loe  = wr_q;
        // Read data is captured on the final strobe cycle, only for the granted port.
        if (cnt_q <= 8'd1) begin
          state_d = HOLD;
          if (!wr_q) begin
            if (gnt_b_q) b_rdata_d = bus.sram_din;
            else         a_rdata_d = bus.sram_din;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        lce1    = 1'b0;
        ce2     = 1'b1;
        doe     = wr_q;
        a_ack   = !gnt_b_q;
        b_ack   = gnt_b_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sram_addr = addr_q;
  assign bus.sram_dout = wdata_q;
  assign bus.sram_lce1 = lce1;
  assign bus.sram_ce2  = ce2;
  assign bus.sram_lwe  = lwe;
  assign bus.sram_loe  = loe;
  assign bus.sram_doe  = doe;
  assign bus.a_ack     = a_ack;
  assign bus.b_ack     = b_ack;
  assign bus.a_rdata   = a_rdata_q;
  assign bus.b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_cy6264_ctrl.sv
// Randomized self-checking bench for cy6264_ctrl: two instances (2/2 and 1/5 wait
// cycles), each on a behavioural CY6264, compared against a transaction-level model.
module tb_cy6264_ctrl;

  localparam int RD0 = 2;
  localparam int WR0 = 2;
  localparam int RD1 = 1;
  localparam int WR1 = 5;

  logic clk = 1'b0;
  logic lrst;
  always #5 clk = ~clk;

  cy6264_ctrl_if if0 ();
  cy6264_ctrl_if if1 ();

  cy6264_ctrl #(.WAIT_RD(RD0), .WAIT_WR(WR0)) dut0 (.clk(clk), .lrst(lrst), .bus(if0));
  cy6264_ctrl #(.WAIT_RD(RD1), .WAIT_WR(WR1)) dut1 (.clk(clk), .lrst(lrst), .bus(if1));

  // Behavioural CY6264 chips on each controller's pins.
  logic [7:0] mem0 [8192];
  logic [7:0] mem1 [8192];

  always @(posedge clk) begin
    if (!if0.sram_lce1 && if0.sram_ce2 && !if0.sram_lwe && if0.sram_doe) mem0[if0.sram_addr] = if0.sram_dout;
    if (!if1.sram_lce1 && if1.sram_ce2 && !if1.sram_lwe && if1.sram_doe) mem1[if1.sram_addr] = if1.sram_dout;
  end

  assign if0.sram_din = (!if0.sram_lce1 && if0.sram_ce2 && !if0.sram_loe) ? mem0[if0.sram_addr] : 8'h00;
  assign if1.sram_din = (!if1.sram_lce1 && if1.sram_ce2 && !if1.sram_loe) ? mem1[if1.sram_addr] : 8'h00;

  int checks = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level reference state.
  logic [7:0]  refMem [8192];
  bit          lastB;
  logic [7:0]  expRdA, expRdB;
  bit          opWrA, opWrB;
  logic [12:0] opAddrA, opAddrB;
  logic [7:0]  opDataA, opDataB;

  // Pin-level monitor: strobe exclusivity, strobe widths and address/data stability.
  int          lweCnt [2];
  int          loeCnt [2];
  logic        prevLwe [2];
  logic        prevLoe [2];
  logic [12:0] prevAddr [2];
  logic [8:0]  prevDbus [2];

  task automatic monStep(input int id, input int wWr, input int wRd, input logic lwe,
                         input logic loe, input logic [12:0] addr, input logic [8:0] dbus);
    if (!lrst) begin
      lweCnt[id]  = 0;
      loeCnt[id]  = 0;
      prevLwe[id] = 1'b1;
      prevLoe[id] = 1'b1;
    end else begin
      if (!lwe || !loe) checkOutput($sformatf("strobeOverlap%0d", id), 32'(lwe | loe), 1);
      if (!lwe || !prevLwe[id]) begin
        checkOutput($sformatf("wrAddrStable%0d", id), 32'(addr), 32'(prevAddr[id]));
        checkOutput($sformatf("wrDataStable%0d", id), 32'(dbus), 32'(prevDbus[id]));
      end
      if (!loe || !prevLoe[id]) checkOutput($sformatf("rdAddrStable%0d", id), 32'(addr), 32'(prevAddr[id]));
      if (!lwe) lweCnt[id]++;
      else if (!prevLwe[id]) begin
        checkOutput($sformatf("lweWidth%0d", id), lweCnt[id], wWr);
        lweCnt[id] = 0;
      end
      if (!loe) loeCnt[id]++;
      else if (!prevLoe[id]) begin
        checkOutput($sformatf("loeWidth%0d", id), loeCnt[id], wRd);
        loeCnt[id] = 0;
      end
      prevLwe[id] = lwe;
      prevLoe[id] = loe;
    end
    prevAddr[id] = addr;
    prevDbus[id] = dbus;
  endtask

  always @(negedge clk) begin
    monStep(0, WR0, RD0, if0.sram_lwe, if0.sram_loe, if0.sram_addr, {if0.sram_doe, if0.sram_dout});
    monStep(1, WR1, RD1, if1.sram_lwe, if1.sram_loe, if1.sram_addr, {if1.sram_doe, if1.sram_dout});
  end

  // Runs one request round on dut0 using the opXxx variables; predicts grant order and ack cycles.
  task automatic applyStimulus(input bit useA, input bit useB, input bit scramble);
    int wA, wB, tA, tB, tEnd;
    bit doneA, doneB, anyA, anyB, winA;
    wA = opWrA ? WR0 : RD0;
    wB = opWrB ? WR0 : RD0;
    tA = 0; tB = 0;
    doneA = 0; doneB = 0; anyA = 0; anyB = 0;
    if (useA && useB) begin
      if (lastB) begin tA = wA + 2; tB = wA + wB + 5; lastB = 1'b1; end
      else       begin tB = wB + 2; tA = wA + wB + 5; lastB = 1'b0; end
    end else if (useA) begin
      tA = wA + 2; lastB = 1'b0;
    end else if (useB) begin
      tB = wB + 2; lastB = 1'b1;
    end
    winA = useA && (!useB || tA < tB);
    tEnd = ((tA > tB) ? tA : tB) + 1;
    if0.a_req = useA; if0.a_wr = opWrA; if0.a_addr = opAddrA; if0.a_wdata = opDataA;
    if0.b_req = useB; if0.b_wr = opWrB; if0.b_addr = opAddrB; if0.b_wdata = opDataB;
    for (int t = 1; t <= tEnd; t++) begin
      tick();
      anyA |= bit'(if0.a_ack);
      anyB |= bit'(if0.b_ack);
      // The winner's request has been latched: drop it and garble its inputs.
      if (t == 1 && scramble) begin
        if (winA) begin
          if0.a_req = 1'b0; if0.a_wr = 1'($urandom); if0.a_addr = 13'($urandom); if0.a_wdata = 8'($urandom);
        end else begin
          if0.b_req = 1'b0; if0.b_wr = 1'($urandom); if0.b_addr = 13'($urandom); if0.b_wdata = 8'($urandom);
        end
      end
      if (useA && doneA && t == tA + 1) checkOutput("ackPulseA", 32'(if0.a_ack), 0);
      else if (useA && !doneA && if0.a_ack) begin
        doneA = 1;
        checkOutput("ackTimeA", t, tA);
        if (opWrA) refMem[opAddrA] = opDataA;
        else expRdA = refMem[opAddrA];
        checkOutput("rdataA", 32'(if0.a_rdata), 32'(expRdA));
        checkOutput("rdataKeepB", 32'(if0.b_rdata), 32'(expRdB));
        if0.a_req = 1'b0;
      end
      if (useB && doneB && t == tB + 1) checkOutput("ackPulseB", 32'(if0.b_ack), 0);
      else if (useB && !doneB && if0.b_ack) begin
        doneB = 1;
        checkOutput("ackTimeB", t, tB);
        if (opWrB) refMem[opAddrB] = opDataB;
        else expRdB = refMem[opAddrB];
        checkOutput("rdataB", 32'(if0.b_rdata), 32'(expRdB));
        checkOutput("rdataKeepA", 32'(if0.a_rdata), 32'(expRdA));
        if0.b_req = 1'b0;
      end
    end
    if (useA) checkOutput("ackSeenA", 32'(doneA), 1); else checkOutput("noAckA", 32'(anyA), 0);
    if (useB) checkOutput("ackSeenB", 32'(doneB), 1); else checkOutput("noAckB", 32'(anyB), 0);
    if0.a_req = 1'b0;
    if0.b_req = 1'b0;
  endtask

  // Single port-A transaction on dut1; checks ack cycle, read data and return to IDLE.
  task automatic runDut1(input bit wr, input logic [12:0] addr, input logic [7:0] data, input int w);
    bit seen;
    int tAck;
    seen = 0;
    tAck = 0;
    if1.a_req = 1'b1; if1.a_wr = wr; if1.a_addr = addr; if1.a_wdata = data;
    for (int t = 1; t <= 20 && !seen; t++) begin
      tick();
      if (if1.a_ack) begin
        seen = 1;
        tAck = t;
        if1.a_req = 1'b0;
        if (!wr) checkOutput("d1Rdata", 32'(if1.a_rdata), 32'(data));
      end
    end
    if1.a_req = 1'b0;
    checkOutput("d1AckTime", tAck, w + 2);
    tick();
    checkOutput("d1IdleAfter", {if1.sram_lce1, if1.sram_ce2}, 2'b10);
    checkOutput("d1RdataB", 32'(if1.b_rdata), 0);
  endtask

  task automatic resetModel();
    lastB  = 1'b1;
    expRdA = 8'd0;
    expRdB = 8'd0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int nAck;
    for (int i = 0; i < 8192; i++) begin
      mem0[i] = 8'd0; mem1[i] = 8'd0; refMem[i] = 8'd0;
    end
    resetModel();
    lrst = 1'b0;
    if0.a_req = 1'b1; if0.a_wr = 1'b0; if0.a_addr = 13'h0010; if0.a_wdata = 8'd0;
    if0.b_req = 1'b0; if0.b_wr = 1'b0; if0.b_addr = 13'h0; if0.b_wdata = 8'd0;
    if1.a_req = 1'b0; if1.a_wr = 1'b0; if1.a_addr = 13'h0; if1.a_wdata = 8'd0;
    if1.b_req = 1'b0; if1.b_wr = 1'b0; if1.b_addr = 13'h0; if1.b_wdata = 8'd0;

    repeat (3) tick();
    checkOutput("rstCtrl", {if0.sram_lce1, if0.sram_ce2, if0.sram_lwe, if0.sram_loe, if0.sram_doe}, 5'b10110);
    checkOutput("rstAck", {if0.a_ack, if0.b_ack}, 0);
    checkOutput("rstAddr", 32'(if0.sram_addr), 0);
    checkOutput("rstDout", 32'(if0.sram_dout), 0);
    checkOutput("rstRdata", {if0.a_rdata, if0.b_rdata}, 0);

    lrst = 1'b1;
    opWrA = 1'b0; opAddrA = 13'h0010; opDataA = 8'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    opWrA = 1'b1; opAddrA = 13'h007D; opDataA = 8'd125;
    applyStimulus(1'b1, 1'b0, 1'b0);
    opWrA = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int mode;
      mode    = int'($urandom_range(0, 2));
      opWrA   = 1'($urandom_range(0, 1));
      opAddrA = 13'h0100 + 13'($urandom_range(0, 7));
      opDataA = 8'($urandom);
      opWrB   = 1'($urandom_range(0, 1));
      opAddrB = 13'h0100 + 13'($urandom_range(0, 7));
      opDataB = 8'($urandom);
      applyStimulus(mode != 1, mode != 0, 1'($urandom_range(0, 1)));
    end

    lrst = 1'b0;
    repeat (2) tick();
    checkOutput("rst2Rdata", {if0.a_rdata, if0.b_rdata}, 0);
    resetModel();
    if0.a_req = 1'b1; if0.a_wr = 1'b1; if0.a_addr = 13'h0045; if0.a_wdata = 8'd69;
    if0.b_req = 1'b1; if0.b_wr = 1'b1; if0.b_addr = 13'h00FF; if0.b_wdata = 8'd255;
    lrst = 1'b1;
    nAck = 0;
    for (int t = 1; t <= 40 && nAck < 4; t++) begin
      tick();
      if (if0.a_ack || if0.b_ack) begin
        checkOutput("altPort", 32'(if0.b_ack), nAck % 2);
        checkOutput("altTime", t, (WR0 + 2) + (WR0 + 3) * nAck);
        nAck++;
        if (nAck == 4) begin if0.a_req = 1'b0; if0.b_req = 1'b0; end
      end
    end
    checkOutput("altCount", nAck, 4);
    if0.a_req = 1'b0; if0.b_req = 1'b0;
    tick();
    refMem[13'h0045] = 8'd69;
    refMem[13'h00FF] = 8'd255;
    lastB = 1'b1;

    opWrA = 1'b0; opAddrA = 13'h0045;
    opWrB = 1'b0; opAddrB = 13'h00FF;
    applyStimulus(1'b1, 1'b1, 1'b0);

    if0.b_req = 1'b1; if0.b_wr = 1'b0; if0.b_addr = 13'h00FF;
    repeat (3) tick();
    checkOutput("abortInAccess", 32'(if0.sram_loe), 0);
    lrst = 1'b0;
    if0.b_req = 1'b0;
    tick();
    checkOutput("abortAck", 32'(if0.b_ack), 0);
    checkOutput("abortRdata", 32'(if0.b_rdata), 0);
    checkOutput("abortDeselect", {if0.sram_lce1, if0.sram_ce2, if0.sram_loe}, 3'b101);
    lrst = 1'b1;
    resetModel();
    tick();

    runDut1(1'b1, 13'h00AA, 8'h5A, WR1);
    runDut1(1'b0, 13'h00AA, 8'h5A, RD1);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cy6264_ctrl.md
# cy6264_ctrl

Synchronous two-requester controller for the CY6264 8K x 8 asynchronous SRAM. Two clients present level-held read/write requests; a round-robin arbiter grants one at a time and a sequencer FSM drives the chip's async pins with programmable setup, strobe and hold cycles. The CY6264 `io` bus is resolved at the top level from `sram_dout`/`sram_doe`/`sram_din`.

## Interface
- `WAIT_RD`, default 2: cycles `loe` is held low per read (1..255).
- `WAIT_WR`, default 2: cycles `lwe` is held low per write (1..255).
- `clk`  in  1  system clock, rising edge.
- `lrst`  in  1  reset; synchronous, active-low.
- `a_req`  in  1  port A request (level, held until `a_ack`).
- `a_wr`  in  1  port A: 1 = write, 0 = read.
- `a_addr`  in  13  port A address.
- `a_wdata`  in  8  port A write data.
- `a_ack`  out  1  port A one-cycle completion pulse.
- `a_rdata`  out  8  port A last read data (registered).
- `b_req`, `b_wr`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as port A, for port B.
- `sram_addr`  out  13  to CY6264 `addr`.
- `sram_lce1`  out  1  chip enable 1, active-low.
- `sram_ce2`  out  1  chip enable 2, active-high.
- `sram_lwe`  out  1  write enable, active-low.
- `sram_loe`  out  1  output enable, active-low.
- `sram_dout`  out  8  write data toward `io`.
- `sram_doe`  out  1  1 = controller drives `io`.
- `sram_din`  in  8  `io` sampled.

## Operation
- States: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- IDLE: chip deselected (`lce1=1`, `ce2=0`, `lwe=1`, `loe=1`, `doe=0`). If any req is high, the controller grants one port, latches its addr/wr/wdata, and moves to SETUP.
- Arbitration: the only requester wins. On a tie, the winner is the port not granted last. The `last` register resets to B, so A wins the first tie.
- SETUP (1 cycle): `sram_addr` is driven and `lce1=0`, `ce2=1`. For a write, `doe=1` and `sram_dout`=wdata. `lwe`/`loe` stay high.
- ACCESS: the counter loads WAIT_RD or WAIT_WR.
  - Write: `lwe=0`.
  - Read: `loe=0`, `doe=0`.
  - The state is left when the counter reaches 1.
  - On the last read ACCESS cycle, `sram_din` is registered into the granted port's rdata.
- HOLD (1 cycle): `lwe=1`, `loe=1`. Addr, enables and write data (`doe`) are held. The granted port's ack is 1. Next state is IDLE.
- Latched addr/wdata/wr are used throughout; requester input changes after the grant are ignored.
- If req drops mid-transaction, the transaction still completes and ack still pulses.
- The other port's rdata is never modified.

## Timing
- Reset (`lrst=0` at an edge, any state): next state IDLE; `sram_lce1=1`, `sram_ce2=0`, `sram_lwe=1`, `sram_loe=1`, `sram_doe=0`, `sram_addr=0`, `sram_dout=0`, `a_ack=b_ack=0`, `a_rdata=b_rdata=0`, `last`=B.
  - A reset mid-ACCESS aborts the cycle with no ack and no rdata update.
- Transaction (request seen in IDLE at cycle 0):
  - SETUP at cycle 1.
  - ACCESS at cycles 2..1+W.
  - HOLD/ack at cycle 2+W.
  - IDLE at cycle 3+W.
  - Throughput: one transaction per W+3 cycles.
- Read data is valid in `x_rdata` in the cycle ack is high and persists until that port's next read.
- Handshake: req is sampled only in IDLE. If a requester still drives req high at the IDLE cycle following its ack, that is a new transaction.
  - With both requesters continuously requesting, grants strictly alternate A, B, A, ...
- `lwe` and `loe` are never low simultaneously. Address and data are stable one cycle before a strobe falls and one cycle after it rises.
- Counter: 8-bit, loads W, decrements to 1. W=1 gives a single ACCESS cycle.

## Test plan
- Reset: hold `lrst=0` 3 cycles with `a_req=1` -> all outputs at their reset values and no ack. Release `lrst` -> grant to A on the next IDLE cycle.
- Port A write then read, WAIT_WR=WAIT_RD=2, with a CY6264 model on `io`:
  - Write addr 13'h007D, data 8'd125 -> `lwe` low exactly 2 cycles; `a_ack` at cycle 4 after the request is seen.
  - Read 13'h007D -> `a_rdata=8'd125` with `a_ack`; `b_rdata` unchanged at 0.
- Simultaneous: A and B both request from reset, writing 13'h0045 := 8'd69 and 13'h00FF := 8'd255, held continuously -> order A, B, A, B.
  - Readback of both addresses returns 69 and 255.
- Abort: reset asserted during B's read ACCESS cycle -> no `b_ack`, `b_rdata` unchanged; chip deselected on the next cycle.
- WAIT_RD=1, WAIT_WR=5: check strobe widths 1 and 5 and transaction lengths 4 and 8 cycles.
  - Check `lwe`/`loe` never overlap, and that addr/dout are stable one cycle around each strobe.
